// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multi-cycle MIPS control FSM. It walks each instruction through fetch,
// decode, execute, memory and writeback, and drives the datapath enables and
// mux selects. It also handles the memory and multiplier handshakes and gives
// up on a memory access that never completes. ALUControl and the destination
// register select still come from the separate instruction decoder.
//
// Optional feature: define MIPS_CTRL_RETIRE_CNT_EN to add the 32-bit
// retired_cnt output, which counts completed instructions.
module mips_multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ready,
   input  logic        mult_done,
   output logic        pc_write,
   output logic        ir_write,
   output logic        iord,
   output logic        mem_read,
   output logic        mem_write,
   output logic        reg_write,
   output logic        alu_srca,
   output logic [1:0]  alu_srcb,
   output logic [1:0]  pc_src,
   output logic        mult_start,
   output logic        illegal,
   output logic        bus_error,
   output logic [3:0]  state
`ifdef MIPS_CTRL_RETIRE_CNT_EN
   ,
   output logic [31:0] retired_cnt
`endif
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WB   = 4'd6,
      S_MEM_WR   = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_JR       = 4'd10,
      S_MULT     = 4'd11,
      S_WB       = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_MULT  = 6'h18;

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

   state_t           r_state;
   state_t           w_next;
   logic             r_quiet;
   logic             r_multWait;
   logic [CNT_W-1:0] r_memCnt;
   logic             w_quiet;
   logic             w_memState;
   logic             w_timeUp;
   logic             w_abort;
   logic             w_cntClear;

   // The cycle reset is seen and the cycle after it are both kept silent,
   // so a strobe that was active when reset hit cannot leak into the datapath.
   assign w_quiet    = reset | r_quiet;
   assign w_memState = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                       (r_state == S_MEM_WR);
   assign w_timeUp   = (r_memCnt == TIMEOUT_CNT) && !mem_ready;
   assign w_cntClear = r_quiet || !w_memState || w_abort || (w_next != r_state);

   // State register; reset always lands in FETCH
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Marks the single silent cycle that follows the last reset cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_quiet <= 1'b1;
      end else begin
         r_quiet <= 1'b0;
      end
   end

   // Counts cycles spent waiting on memory; restarts on every entry to a memory state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_memCnt <= '0;
      end else if (w_cntClear) begin
         r_memCnt <= '0;
      end else if (!mem_ready) begin
         r_memCnt <= r_memCnt + CNT_W'(1);
      end
   end

   // Remembers that the multiplier start pulse was already issued for this MULT visit
   always_ff @(posedge clk) begin
      if (reset) begin
         r_multWait <= 1'b0;
      end else begin
         r_multWait <= (r_state == S_MULT) && !mult_done && !r_quiet;
      end
   end

   // Next-state and output decode; completion qualifiers gate pc_write, ir_write and reg_write
   always_comb begin
      w_next     = r_state;
      w_abort    = 1'b0;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      alu_srca   = 1'b0;
      alu_srcb   = 2'd0;
      pc_src     = 2'd0;
      mult_start = 1'b0;
      illegal    = 1'b0;
      bus_error  = 1'b0;
      state      = r_state;

      case (r_state)
         S_FETCH: begin
            mem_read = 1'b1;
            alu_srcb = 2'd1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               w_next   = S_DECODE;
            end else if (w_timeUp) begin
               bus_error = 1'b1;
               w_abort   = 1'b1;
               w_next    = S_FETCH;
            end
         end

         S_DECODE: begin
            alu_srcb = 2'd3;
            case (opcode)
               OP_RTYPE: begin
                  if (funct == FN_MULT) begin
                     w_next = S_MULT;
                  end else if (funct == FN_JR) begin
                     w_next = S_JR;
                  end else begin
                     w_next = S_EXEC_R;
                  end
               end
               OP_LW, OP_SW:   w_next = S_MEM_ADDR;
               OP_BEQ, OP_BNE: w_next = S_BRANCH;
               OP_J, OP_JAL:   w_next = S_JUMP;
               OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: w_next = S_EXEC_I;
               default: begin
                  illegal = 1'b1;
                  w_next  = S_FETCH;
               end
            endcase
         end

         S_EXEC_R: begin
            alu_srca = 1'b1;
            w_next   = S_WB;
         end

         S_EXEC_I: begin
            alu_srca = 1'b1;
            alu_srcb = 2'd2;
            w_next   = S_WB;
         end

         S_WB: begin
            reg_write = 1'b1;
            w_next    = S_FETCH;
         end

         S_MEM_ADDR: begin
            alu_srca = 1'b1;
            alu_srcb = 2'd2;
            w_next   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end

         S_MEM_RD: begin
            iord     = 1'b1;
            mem_read = 1'b1;
            if (mem_ready) begin
               w_next = S_MEM_WB;
            end else if (w_timeUp) begin
               bus_error = 1'b1;
               w_abort   = 1'b1;
               w_next    = S_FETCH;
            end
         end

         S_MEM_WB: begin
            reg_write = 1'b1;
            w_next    = S_FETCH;
         end

         S_MEM_WR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) begin
               w_next = S_FETCH;
            end else if (w_timeUp) begin
               bus_error = 1'b1;
               w_abort   = 1'b1;
               w_next    = S_FETCH;
            end
         end

         S_BRANCH: begin
            alu_srca = 1'b1;
            pc_src   = 2'd1;
            pc_write = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
            w_next   = S_FETCH;
         end

         S_JUMP: begin
            pc_src    = 2'd2;
            pc_write  = 1'b1;
            reg_write = (opcode == OP_JAL);
            w_next    = S_FETCH;
         end

         S_JR: begin
            pc_src   = 2'd3;
            pc_write = 1'b1;
            w_next   = S_FETCH;
         end

         S_MULT: begin
            mult_start = !r_multWait;
            if (mult_done) begin
               w_next = S_FETCH;
            end
         end

         default: begin
            w_next = S_FETCH;
         end
      endcase

      if (w_quiet) begin
         w_next     = S_FETCH;
         w_abort    = 1'b0;
         pc_write   = 1'b0;
         ir_write   = 1'b0;
         iord       = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         reg_write  = 1'b0;
         alu_srca   = 1'b0;
         alu_srcb   = 2'd0;
         pc_src     = 2'd0;
         mult_start = 1'b0;
         illegal    = 1'b0;
         bus_error  = 1'b0;
         state      = 4'd0;
      end
   end

`ifdef MIPS_CTRL_RETIRE_CNT_EN
   logic        w_retire;
   logic [31:0] r_retired;

   // An instruction retires on the last cycle of its sequence; aborts never count
   always_comb begin
      w_retire = 1'b0;
      if (!w_quiet) begin
         case (r_state)
            S_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_JR: w_retire = 1'b1;
            S_MEM_WR: w_retire = mem_ready;
            S_MULT:   w_retire = mult_done;
            default:  w_retire = 1'b0;
         endcase
      end
   end

   // Free-running retired-instruction counter, wraps naturally at 32 bits
   always_ff @(posedge clk) begin
      if (reset) begin
         r_retired <= 32'd0;
      end else if (w_retire) begin
         r_retired <= r_retired + 32'd1;
      end
   end

   assign retired_cnt = r_retired;
`endif

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the MIPS datapath: fetch, decode, execute, memory and writeback.
- Drives register enables and mux selects for PC, IR, memory, register file, ALU operand muxes and the multiplier.
- Waits on memory and multiplier handshakes and applies a bounded memory-wait timeout.
- Sits beside the instruction decoder, which still supplies ALUControl and destination selection.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent waiting for mem_ready in any memory state before abort; minimum 1.
- CNT_W, 5: width of the memory-wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  6  IR[31:26], valid from DECODE onward
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory access completes this cycle
- mult_done  input  1  multiplier result valid, single-cycle pulse
- pc_write  output  1  PC load enable
- ir_write  output  1  IR load enable
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- reg_write  output  1  register-file write enable
- alu_srca  output  1  0 = PC, 1 = rs
- alu_srcb  output  2  0 = rt, 1 = const 4, 2 = sign-extended immediate, 3 = immediate<<2
- pc_src  output  2  0 = ALU result, 1 = ALUOut (branch target), 2 = jump target, 3 = rs (jr)
- mult_start  output  1  one-cycle start pulse to the multiplier
- illegal  output  1  one-cycle pulse on an unknown opcode
- bus_error  output  1  one-cycle pulse on memory timeout
- state  output  4  current state encoding, for debug

Behaviour:
- Reset: state = FETCH (0). All outputs 0 on the cycle reset is sampled and on the following cycle.
- Reset mid-operation aborts immediately; no strobe stays asserted after reset.
- Outputs are Moore-decoded from state, except the pc_write, ir_write and reg_write completion qualifiers listed below.
- State encodings: FETCH = 0, DECODE = 1, EXEC_R = 2, EXEC_I = 3, MEM_ADDR = 4, MEM_RD = 5, MEM_WB = 6, MEM_WR = 7, BRANCH = 8, JUMP = 9, JR = 10, MULT = 11, WB = 12.
- FETCH:
  - mem_read = 1, iord = 0, alu_srca = 0, alu_srcb = 1, pc_src = 0.
  - On mem_ready: ir_write = 1 and pc_write = 1 in that same cycle, then go to DECODE.
- DECODE (1 cycle): alu_srca = 0, alu_srcb = 3 (precomputes the branch target). Dispatch on opcode:
  - 0x00 with funct 0x18 -> MULT.
  - 0x00 with funct 0x08 -> JR.
  - Any other 0x00 -> EXEC_R.
  - 0x23 or 0x2B -> MEM_ADDR.
  - 0x04 or 0x05 -> BRANCH.
  - 0x02 or 0x03 -> JUMP.
  - 0x08, 0x0A, 0x0C, 0x0D, 0x0F -> EXEC_I.
  - Anything else: illegal = 1 for one cycle, then FETCH.
- EXEC_R: alu_srca = 1, alu_srcb = 0, then WB.
- EXEC_I: alu_srca = 1, alu_srcb = 2, then WB.
- WB: reg_write = 1 for one cycle, then FETCH.
- MEM_ADDR: alu_srca = 1, alu_srcb = 2. Go to MEM_RD for 0x23, MEM_WR for 0x2B.
- MEM_RD: iord = 1, mem_read = 1. On mem_ready go to MEM_WB.
- MEM_WB: reg_write = 1, then FETCH.
- MEM_WR: iord = 1, mem_write = 1. On mem_ready go to FETCH.
- BRANCH:
  - alu_srca = 1, alu_srcb = 0, pc_src = 1.
  - pc_write = 1 if (opcode = 0x04 and zero) or (opcode = 0x05 and !zero).
  - Then FETCH.
- JUMP: pc_src = 2, pc_write = 1. For 0x03 also reg_write = 1 (link). Then FETCH.
- JR: pc_src = 3, pc_write = 1, then FETCH.
- MULT:
  - mult_start = 1 on the entry cycle only.
  - Remain in MULT until mult_done, then FETCH.
  - mult_done arriving on the entry cycle is honoured.
- Memory timeout (FETCH, MEM_RD, MEM_WR):
  - Counter clears on entry to each of these states and increments each cycle that mem_ready = 0.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0: bus_error = 1 for one cycle, then FETCH. No ir_write, pc_write or reg_write occurs.
  - mem_ready arriving in the same cycle the count reaches MEM_TIMEOUT wins: normal completion, no bus_error.
- Latency with mem_ready tied high: R-type 4 cycles, I-type ALU 4, lw 5, sw 4, branch 3, j/jal/jr 3.

Optional Feature:
- Macro: MIPS_CTRL_RETIRE_CNT_EN.
- When defined:
  - Adds output retired_cnt, 32 bits, reset value 0.
  - Increments by 1 on every instruction completion: the final cycle of WB, MEM_WB, MEM_WR (with mem_ready), BRANCH, JUMP, JR, and MULT (with mult_done).
  - Does not count illegal dispatch or bus_error aborts.
  - Wraps from 0xFFFFFFFF to 0.
- When not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- reset held 3 cycles mid MEM_RD -> state = 0 and all strobes 0 on the next cycle; first FETCH mem_read = 1.
- mem_ready tied 1, add (opcode 0x00, funct 0x20) -> state sequence 0, 1, 2, 12, 0; reg_write high exactly in cycle 4; ir_write and pc_write high only in cycle 1.
- lw (0x23) with mem_ready low for 3 cycles in MEM_RD -> stays in 5 for 3 cycles; reg_write asserted once in state 6; total 8 cycles.
- beq (0x04) with zero = 1, then bne (0x05) with zero = 1 -> pc_write = 1 with pc_src = 1 in BRANCH for beq; pc_write = 0 for bne.
- mult (funct 0x18) with mult_done 5 cycles after mult_start -> single mult_start pulse; 5 cycles in state 11, then FETCH.
- MEM_TIMEOUT = 16 and mem_ready never asserted during a sw -> bus_error pulses once after 16 wait cycles; return to FETCH; mem_write deasserts; with MIPS_CTRL_RETIRE_CNT_EN defined, retired_cnt is unchanged.
